// File: rtl/eth_rx_pkg.sv
// Shared types and constants for the MII/GMII receive front end.
package eth_rx_pkg;

  typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, DROP} rx_state_t;

  localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE      = 8'hD5;
  localparam logic [3:0] PREAMBLE_NIB  = 4'h5;
  localparam logic [3:0] SFD_NIB       = 4'hD;

  typedef enum logic [1:0] {UnitPre, UnitSfd, UnitBad} unit_kind_t;

  typedef struct packed {
    logic       valid;
    logic       sof;
    logic       eof;
    logic       err;
    logic [7:0] data;
  } rx_beat_t;

  // In MII mode only the low nibble carries the unit.
  function automatic unit_kind_t classify_unit(input logic gmii, input logic [7:0] value);
    unit_kind_t kind;
    if (gmii) begin
      kind = (value == SFD_BYTE) ? UnitSfd : (value == PREAMBLE_BYTE) ? UnitPre : UnitBad;
    end else begin
      kind = (value[3:0] == SFD_NIB) ? UnitSfd :
             (value[3:0] == PREAMBLE_NIB) ? UnitPre : UnitBad;
    end
    return kind;
  endfunction

endpackage

// File: rtl/eth_sync_ff.sv
// Plain flop-chain synchroniser with synchronous active-low reset.
module eth_sync_ff #(
  parameter int unsigned WIDTH  = 1,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] sync_q [STAGES];

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      sync_q <= '{default: '0};
    end else begin
      sync_q[0] <= d_i;
      for (int unsigned i = 1; i < STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/mii_gmii_rx_frontend.sv
// MII/GMII receive front end: registers PHY pins, strips preamble/SFD, packs MII nibbles
// and emits a flagged byte stream towards the MAC RX path.
module mii_gmii_rx_frontend
  import eth_rx_pkg::*;
#(
  parameter int unsigned PIPE_STAGES  = 1,
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned MAX_PREAMBLE = 15
) (
  input  logic       rx_clk_i,
  input  logic       reset_i,
  input  logic       mode_gmii_i,
  input  logic       rx_dv_i,
  input  logic [7:0] rxd_i,
  input  logic       rx_er_i,
  input  logic       col_i,
  input  logic       crs_i,
  output logic [7:0] data_o,
  output logic       data_valid_o,
  output logic       sof_o,
  output logic       eof_o,
  output logic       err_o,
  output logic       drop_o,
  output logic       col_o,
  output logic       crs_o
);

  localparam int unsigned CntW = $clog2(2 * MAX_PREAMBLE + 3);
  localparam logic [CntW-1:0] MaxPre = CntW'(MAX_PREAMBLE);

  logic            dv_q, er_q, mode_in_q;
  logic [7:0]      rxd_q;
  rx_state_t       state_q, state_d;
  logic            mode_q, mode_d;
  logic [CntW-1:0] pre_cnt_q, pre_cnt_d, pre_next;
  logic [7:0]      hold_q, hold_d;
  logic            hold_vld_q, hold_vld_d;
  logic [3:0]      low_q, low_d;
  logic            nib_odd_q, nib_odd_d;
  logic            err_acc_q, err_acc_d;
  logic            first_q, first_d;
  logic            drop_q, drop_d;
  rx_beat_t        rel_q, rel_d;
  unit_kind_t      kind;
  logic            unit_gmii, pre_over, byte_done;
  logic [7:0]      byte_val;

  // The first unit of a frame is judged with the mode captured alongside it.
  assign unit_gmii = (state_q == IDLE) ? mode_in_q : mode_q;
  assign kind      = classify_unit(unit_gmii, rxd_q);
  assign pre_next  = ((state_q == IDLE) ? '0 : pre_cnt_q) + CntW'(1);
  assign pre_over  = unit_gmii ? (pre_next > MaxPre) : ((pre_next >> 1) > MaxPre);

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    pre_cnt_d  = pre_cnt_q;
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
    low_d      = low_q;
    nib_odd_d  = nib_odd_q;
    err_acc_d  = err_acc_q;
    first_d    = first_q;
    drop_d     = 1'b0;
    rel_d      = '0;
    byte_done  = 1'b0;
    byte_val   = 8'h00;

    unique case (state_q)
      IDLE, PREAMBLE: begin
        if (state_q == IDLE) mode_d = mode_in_q;
        if (!dv_q) begin
          state_d = IDLE;
        end else if (er_q || kind == UnitBad || (kind == UnitPre && pre_over)) begin
          state_d = DROP;
          drop_d  = 1'b1;
        end else if (kind == UnitSfd) begin
          state_d    = DATA;
          hold_vld_d = 1'b0;
          nib_odd_d  = 1'b0;
          err_acc_d  = 1'b0;
          first_d    = 1'b1;
        end else begin
          state_d   = PREAMBLE;
          pre_cnt_d = pre_next;
        end
      end

      DATA: begin
        if (dv_q) begin
          err_acc_d = err_acc_q | er_q;
          if (mode_q) begin
            byte_done = 1'b1;
            byte_val  = rxd_q;
          end else if (!nib_odd_q) begin
            low_d     = rxd_q[3:0];
            nib_odd_d = 1'b1;
          end else begin
            byte_done = 1'b1;
            byte_val  = {rxd_q[3:0], low_q};
            nib_odd_d = 1'b0;
          end
          if (byte_done) begin
            if (hold_vld_q) begin
              rel_d.valid = 1'b1;
              rel_d.sof   = first_q;
              rel_d.data  = hold_q;
              first_d     = 1'b0;
            end
            hold_d     = byte_val;
            hold_vld_d = 1'b1;
          end
        end else begin
          state_d = IDLE;
          if (hold_vld_q) begin
            // A trailing odd nibble is a dribble error on the last full byte.
            rel_d.valid = 1'b1;
            rel_d.sof   = first_q;
            rel_d.eof   = 1'b1;
            rel_d.err   = err_acc_q | nib_odd_q;
            rel_d.data  = hold_q;
          end else if (nib_odd_q) begin
            drop_d = 1'b1;
          end
          hold_vld_d = 1'b0;
          nib_odd_d  = 1'b0;
        end
      end

      DROP: begin
        if (!dv_q) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge rx_clk_i) begin
    if (!reset_i) begin
      dv_q       <= 1'b0;
      er_q       <= 1'b0;
      rxd_q      <= 8'h00;
      mode_in_q  <= 1'b0;
      state_q    <= IDLE;
      mode_q     <= 1'b0;
      pre_cnt_q  <= '0;
      hold_q     <= 8'h00;
      hold_vld_q <= 1'b0;
      low_q      <= 4'h0;
      nib_odd_q  <= 1'b0;
      err_acc_q  <= 1'b0;
      first_q    <= 1'b0;
      drop_q     <= 1'b0;
      rel_q      <= '0;
    end else begin
      dv_q       <= rx_dv_i;
      er_q       <= rx_er_i;
      rxd_q      <= rxd_i;
      mode_in_q  <= mode_gmii_i;
      state_q    <= state_d;
      mode_q     <= mode_d;
      pre_cnt_q  <= pre_cnt_d;
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
      low_q      <= low_d;
      nib_odd_q  <= nib_odd_d;
      err_acc_q  <= err_acc_d;
      first_q    <= first_d;
      drop_q     <= drop_d;
      rel_q      <= rel_d;
    end
  end

  rx_beat_t pipe_beat [PIPE_STAGES+1];
  assign pipe_beat[0] = rel_q;

  for (genvar i = 0; i < PIPE_STAGES; i++) begin : g_pipe
    rx_beat_t beat_q;
    always_ff @(posedge rx_clk_i) begin
      if (!reset_i) beat_q <= '0;
      else          beat_q <= pipe_beat[i];
    end
    assign pipe_beat[i+1] = beat_q;
  end

  assign data_o       = pipe_beat[PIPE_STAGES].data;
  assign data_valid_o = pipe_beat[PIPE_STAGES].valid;
  assign sof_o        = pipe_beat[PIPE_STAGES].sof;
  assign eof_o        = pipe_beat[PIPE_STAGES].eof;
  assign err_o        = pipe_beat[PIPE_STAGES].err;
  assign drop_o       = drop_q;

  eth_sync_ff #(.WIDTH(1), .STAGES(SYNC_STAGES)) u_col_sync (
    .clk_i   (rx_clk_i),
    .reset_i (reset_i),
    .d_i     (col_i),
    .q_o     (col_o)
  );

  eth_sync_ff #(.WIDTH(1), .STAGES(SYNC_STAGES)) u_crs_sync (
    .clk_i   (rx_clk_i),
    .reset_i (reset_i),
    .d_i     (crs_i),
    .q_o     (crs_o)
  );

endmodule

// File: tb/tb_mii_gmii_rx_frontend.sv
// Bench for mii_gmii_rx_frontend: directed cases plus random frames against a frame-level model.
module tb_mii_gmii_rx_frontend;

  localparam int unsigned PipeStages = 1;
  localparam int unsigned SyncStages = 2;
  localparam int unsigned MaxPre     = 15;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       mode_gmii = 1'b0;
  logic       rx_dv = 1'b0;
  logic [7:0] rxd = 8'h00;
  logic       rx_er = 1'b0;
  logic       col = 1'b0;
  logic       crs = 1'b0;
  logic [7:0] data;
  logic       data_valid, sof, eof, err, drop, col_s, crs_s;

  mii_gmii_rx_frontend #(
    .PIPE_STAGES  (PipeStages),
    .SYNC_STAGES  (SyncStages),
    .MAX_PREAMBLE (MaxPre)
  ) dut (
    .rx_clk_i     (clk),
    .reset_i      (reset_n),
    .mode_gmii_i  (mode_gmii),
    .rx_dv_i      (rx_dv),
    .rxd_i        (rxd),
    .rx_er_i      (rx_er),
    .col_i        (col),
    .crs_i        (crs),
    .data_o       (data),
    .data_valid_o (data_valid),
    .sof_o        (sof),
    .eof_o        (eof),
    .err_o        (err),
    .drop_o       (drop),
    .col_o        (col_s),
    .crs_o        (crs_s)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass = 0;
  int n_checks = 0;

  // Beats are {sof, eof, err, data}.
  logic [10:0] got[$];
  logic [10:0] exp_q[$];
  int          drops_got = 0;
  int          exp_drops = 0;
  int          t_first_valid = -1;
  int          t_drop = -1;
  int          t_start = 0;
  logic [7:0]  units[$];
  bit          errs[$];

  always @(negedge clk) begin
    if (data_valid) begin
      if (got.size() == 0) t_first_valid = cyc;
      got.push_back({sof, eof, err, data});
    end
    if (drop) begin
      if (drops_got == 0) t_drop = cyc;
      drops_got++;
    end
  end

  initial begin
    #10000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  function automatic logic [31:0] outs_vec();
    return {17'd0, data, data_valid, sof, eof, err, drop, col_s, crs_s};
  endfunction

  // Frame-level reference: walk the units, decide drop/accept, then cut the payload into beats.
  function automatic void model_frame(input bit gmii, input logic [7:0] u[$], input bit e[$]);
    int         i = 0;
    int         pre = 0;
    int         nibs = 0;
    bit         in_data = 1'b0;
    bit         ferr = 1'b0;
    bit         odd;
    logic [3:0] lo = 4'h0;
    logic [7:0] v;
    logic [7:0] bytes[$];
    while (i < u.size() && !in_data) begin
      v = gmii ? u[i] : {4'h0, u[i][3:0]};
      if (e[i]) begin
        exp_drops++;
        return;
      end
      if (v == (gmii ? 8'hD5 : 8'h0D)) begin
        in_data = 1'b1;
      end else if (v == (gmii ? 8'h55 : 8'h05)) begin
        pre++;
        if ((gmii ? pre : pre / 2) > int'(MaxPre)) begin
          exp_drops++;
          return;
        end
      end else begin
        exp_drops++;
        return;
      end
      i++;
    end
    if (!in_data) return;
    for (; i < u.size(); i++) begin
      ferr |= e[i];
      if (gmii) bytes.push_back(u[i]);
      else begin
        if (nibs % 2 == 0) lo = u[i][3:0];
        else bytes.push_back({u[i][3:0], lo});
        nibs++;
      end
    end
    odd = !gmii && (nibs % 2 == 1);
    if (bytes.size() == 0) begin
      if (odd) exp_drops++;
      return;
    end
    ferr |= odd;
    foreach (bytes[k]) begin
      exp_q.push_back({k == 0, k == bytes.size() - 1, (k == bytes.size() - 1) && ferr, bytes[k]});
    end
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      rx_dv = 1'b0;
      rxd   = 8'h00;
      rx_er = 1'b0;
    end
  endtask

  task automatic drive_frame(input bit gmii, input logic [7:0] u[$], input bit e[$],
                             input bit flip);
    foreach (u[i]) begin
      @(negedge clk);
      if (i == 0) begin
        mode_gmii = gmii;
        t_start   = cyc + 1;
      end
      if (flip && i == 2) mode_gmii = ~gmii;
      rx_dv = 1'b1;
      rxd   = u[i];
      rx_er = e[i];
      crs   = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    rx_dv = 1'b0;
    rxd   = 8'h00;
    rx_er = 1'($urandom_range(0, 1));
  endtask

  task automatic new_frame();
    units.delete();
    errs.delete();
  endtask

  task automatic push(input logic [7:0] v, input bit er);
    units.push_back(v);
    errs.push_back(er);
  endtask

  task automatic begin_check();
    exp_q.delete();
    exp_drops     = 0;
    got.delete();
    drops_got     = 0;
    t_first_valid = -1;
    t_drop        = -1;
  endtask

  task automatic send(input bit gmii, input bit flip);
    model_frame(gmii, units, errs);
    drive_frame(gmii, units, errs, flip);
  endtask

  task automatic check_frame(input string tag);
    check({tag, "_beats"}, got.size(), exp_q.size());
    foreach (exp_q[k]) begin
      check($sformatf("%s_beat%0d", tag, k), (k < got.size()) ? 32'(got[k]) : 32'hffff_ffff,
            32'(exp_q[k]));
    end
    check({tag, "_drops"}, drops_got, exp_drops);
    got.delete();
    drops_got = 0;
  endtask

  task automatic gen_frame(output bit gmii);
    int npre, nb, nun;
    new_frame();
    gmii = 1'($urandom_range(0, 1));
    npre = $urandom_range(0, gmii ? 18 : 34);
    for (int i = 0; i < npre; i++) push(gmii ? 8'h55 : {4'($urandom), 4'h5}, 1'b0);
    if (npre > 0 && $urandom_range(0, 7) == 0) units[$urandom_range(0, npre - 1)] = 8'($urandom);
    push(gmii ? 8'hD5 : {4'($urandom), 4'hD}, 1'b0);
    nb  = $urandom_range(0, 10);
    nun = gmii ? nb : 2 * nb + (($urandom_range(0, 3) == 0) ? 1 : 0);
    for (int i = 0; i < nun; i++) push(8'($urandom), 1'b0);
    foreach (errs[i]) errs[i] = ($urandom_range(0, 29) == 0);
  endtask

  initial begin
    bit g;
    int n;
    repeat (3) @(negedge clk);
    check("reset_outputs", outs_vec(), 32'd0);
    reset_n = 1'b1;
    idle(2);

    // GMII basic frame with latency check.
    begin_check(); new_frame();
    repeat (7) push(8'h55, 1'b0);
    push(8'hD5, 1'b0);
    for (int i = 1; i <= 4; i++) push(8'(i), 1'b0);
    send(1'b1, 1'b0); idle(8);
    check("t1_latency", t_first_valid - t_start, 32'd11);
    check_frame("t1");

    // MII nibble packing, then a dribble nibble.
    begin_check(); new_frame();
    repeat (15) push(8'h05, 1'b0);
    push(8'h0D, 1'b0);
    push(8'h01, 1'b0); push(8'h00, 1'b0); push(8'h02, 1'b0); push(8'h00, 1'b0);
    send(1'b0, 1'b0); idle(8); check_frame("t2a");
    begin_check(); push(8'h07, 1'b0);
    send(1'b0, 1'b0); idle(8); check_frame("t2b");

    // rx_er in payload, then a bad preamble byte.
    begin_check(); new_frame();
    repeat (7) push(8'h55, 1'b0);
    push(8'hD5, 1'b0); push(8'h11, 1'b0); push(8'h22, 1'b1); push(8'h33, 1'b0);
    send(1'b1, 1'b0); idle(8); check_frame("t3a");
    begin_check(); new_frame();
    push(8'h55, 1'b0); push(8'h55, 1'b0); push(8'h5A, 1'b0); push(8'h55, 1'b0);
    push(8'hD5, 1'b0); push(8'h01, 1'b0);
    send(1'b1, 1'b0); idle(8); check_frame("t3b");

    // Over-long preamble, then a frame after a single idle cycle.
    begin_check(); new_frame();
    repeat (20) push(8'h55, 1'b0);
    push(8'hD5, 1'b0); push(8'h01, 1'b0);
    send(1'b1, 1'b0);
    n = t_start;
    new_frame();
    repeat (3) push(8'h55, 1'b0);
    push(8'hD5, 1'b0); push(8'hA1, 1'b0); push(8'hA2, 1'b0); push(8'hA3, 1'b0);
    send(1'b1, 1'b0); idle(8);
    check("t4_drop_time", t_drop - n, 32'd16);
    check_frame("t4");

    // Single-byte frame with no preamble.
    begin_check(); new_frame();
    push(8'hD5, 1'b0); push(8'hAA, 1'b0);
    send(1'b1, 1'b0); idle(8); check_frame("single");

    // Reset in the middle of the payload.
    new_frame();
    repeat (7) push(8'h55, 1'b0);
    push(8'hD5, 1'b0);
    for (int i = 1; i <= 3; i++) push(8'(i), 1'b0);
    mode_gmii = 1'b1;
    foreach (units[i]) begin
      @(negedge clk);
      rx_dv = 1'b1; rxd = units[i]; rx_er = 1'b0;
    end
    @(negedge clk);
    reset_n = 1'b0; rx_dv = 1'b0; rxd = 8'h00;
    @(negedge clk);
    check("t5_reset_outputs", outs_vec(), 32'd0);
    reset_n = 1'b1;
    idle(2);
    begin_check(); new_frame();
    repeat (2) push(8'h55, 1'b0);
    push(8'hD5, 1'b0); push(8'hC1, 1'b0); push(8'hC2, 1'b0);
    send(1'b1, 1'b0); idle(8); check_frame("t5_after");

    // Random frames, sometimes back to back, with mid-frame mode flips and crs noise.
    for (int f = 0; f < 30; f++) begin
      begin_check();
      for (int k = 0; k < int'($urandom_range(1, 2)); k++) begin
        gen_frame(g);
        send(g, ($urandom_range(0, 3) == 0));
      end
      idle(8);
      check_frame($sformatf("rand%0d", f));
    end

    // Synchronisers.
    crs = 1'b0;
    idle(4);
    check("crs_low", crs_s, 32'd0);
    check("col_low", col_s, 32'd0);
    #2 col = 1'b1;
    n = 0;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk);
      #1;
      if (col_s) begin
        n = i;
        break;
      end
    end
    check("col_latency_ok", (n >= int'(SyncStages) && n <= int'(SyncStages) + 1), 32'd1);
    @(negedge clk);
    #2 crs = 1'b1;
    idle(SyncStages + 1);
    check("crs_high", crs_s, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
